ddr5_cmd_timing_checker: RTL and testbench
==========================================

Name: ddr5_cmd_timing_checker

Overview:
- Per-channel DDR5 command-stream timing checker.
- Tracks per-bank open/closed state and elapsed cycles since the last ACT, PRE or REF.
- Checks each accepted command against programmable tRCD/tRP/tRAS/tRFC minimums and basic protocol legality.
- Produces the per-module violation pulse and saturating 16-bit running count consumed by the timing-check aggregator.

Parameters:
- N_BANKS, 32, number of tracked banks (8 bank groups x 4); bank index width is $clog2(N_BANKS).
- TW, 8, width of timing config fields and elapsed timers.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present this cycle
- cmd_type  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 reserved
- cmd_bank  in  $clog2(N_BANKS)  target bank; ignored for PREA/REF/NOP
- cfg_trcd / cfg_trp / cfg_tras / cfg_trfc  in  TW each  minimum distances in clk cycles; 0 disables the check
- clr_count  in  1  synchronous clear of violation_count
- violation_flag  out  1  one-cycle pulse per violating command (drives aggregator violation_flags[i])
- violation_type  out  5  last violation causes: [0] tRCD, [1] tRP, [2] tRAS, [3] tRFC, [4] protocol
- violation_count  out  16  saturating running count (drives timing_violation_count_in[i])
- bank_open  out  N_BANKS  per-bank open state, for debug

Behaviour:
- Reset values:
  - violation_flag = 0, violation_type = 0, violation_count = 0.
  - All banks closed (bank_open = 0).
  - All bank timers and the refresh timer at all-ones, so the first commands pass.
- Distance definition:
  - Each timer loads 1 on the clk edge that accepts its command, then increments each cycle, saturating at 2^TW-1.
  - A command at t2 following its reference command at t1 sees timer = t2 - t1.
  - A check fails when timer < cfg. With cfg = 0 the check never fails.
- One timer per bank: measures time since ACT when the bank is open, time since PRE when it is closed.
- Per-command rules (only when cmd_valid):
  - ACT:
    - bank closed: check tRP against the bank timer and tRFC against the refresh timer.
    - bank open: protocol violation.
    - In all cases the bank becomes open and its timer reloads.
  - RD/WR:
    - bank open: check tRCD.
    - bank closed: protocol violation.
    - No state or timer change.
  - PRE:
    - bank open: check tRAS, then close the bank and reload its timer.
    - bank closed: legal no-op, no timer reload.
  - PREA: check tRAS on every open bank (any fail sets the tRAS bit), then close all open banks and reload their timers.
  - REF:
    - any bank open: protocol violation.
    - The refresh timer reloads regardless.
  - Reserved code 7: protocol violation, no state change.
  - NOP: no action.
- Commands always take effect even when they violate, so the model tracks the DRAM as issued.
- Output latency:
  - Check is registered; violation_flag and violation_type update on the edge after the command (1-cycle latency).
  - violation_type updates only on violating commands and otherwise holds (sticky last).
- Multiple violation causes in one command (e.g. tRP and tRFC on ACT) set multiple type bits but increment the count by exactly 1.
- Count arithmetic:
  - Increments by 1, saturating at 0xFFFF with no wrap.
  - clr_count has priority: clr alone gives 0; clr together with a registering violation gives 1.
- Back-to-back commands every cycle are supported. violation_flag may stay high on consecutive cycles, one pulse per violating command.
- Reset mid-operation: all state returns to reset values immediately. In-flight pulses are dropped; banks are considered closed after reset.

Decomposition:
- Package ddr5_timing_chk_pkg holds:
  - cmd_e enum (3-bit encodings above);
  - violation bit index localparams (VIOL_TRCD..VIOL_PROTO) and the 5-bit viol_t typedef;
  - COUNT_W = 16.
- Sub-module timing_sat_timer: TW-bit saturating up-counter with load-1 input. Instantiated N_BANKS+1 times (banks plus refresh).

Test Plan:
- Config for all scenarios: tRCD=4, tRP=5, tRAS=10, tRFC=20.
- ACT b3 @t0, RD b3 @t3 -> flag @t4, type=00001, count=1. Repeat with RD @t4 -> no flag.
- ACT b0 @t0, PRE b0 @t10 (pass), ACT b0 @t14 -> type=00010, count+1. PRE @t9 in a fresh run -> type=00100.
- REF @t0 (all closed), ACT b1 @t19 -> type=01000. ACT b2 @t20 -> no flag. REF with b5 open -> type=10000.
- RD to closed b7, then ACT on open b3 in back-to-back cycles -> two consecutive flag cycles, type=10000 each, count+2. Cycle ACT after REF+PRE violating both tRP and tRFC -> type=01010, count+1.
- Drive 65540 violations -> count holds 0xFFFF. clr_count with a concurrent violation -> count=1. clr_count alone -> 0.
- ACT b4, drop rst_n mid-stream for 3 cycles -> all outputs 0 during reset. RD b4 after release -> protocol violation (bank closed); ACT b4 immediately -> passes (timers saturated).

Source files
------------

// File: rtl/ddr5_cmd_timing_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr5_timing_chk_pkg
//  Purpose  : Shared types and constants for the DDR5 command timing checker.
//             Holds the command encoding, the violation-cause bit positions
//             and the width of the running violation count.
//  Revision : 1.0 - initial release
// ============================================================================
package ddr5_timing_chk_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6,
        CMD_RSVD = 3'd7
    } cmd_e;

    localparam int VIOL_TRCD  = 0;
    localparam int VIOL_TRP   = 1;
    localparam int VIOL_TRAS  = 2;
    localparam int VIOL_TRFC  = 3;
    localparam int VIOL_PROTO = 4;
    localparam int VIOL_W     = 5;

    typedef logic [VIOL_W-1:0] viol_t;

    localparam int COUNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/ddr5_cmd_timing_checker_timer.sv
`default_nettype none
// ============================================================================
//  Module   : timing_sat_timer
//  Purpose  : TW-bit elapsed-cycle timer. Loads 1 on the edge that accepts
//             its reference command, then counts up and saturates at all-ones.
//             Resets to all-ones so a fresh timer never blocks a command.
//  Ports    : clk, rst_n (async, active-low)
//             load_i  - restart the distance measurement
//             value_o - cycles elapsed since the last load (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module timing_sat_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    output logic [TW-1:0] value_o
);

    logic [TW-1:0] value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '1;
        end else if (load_i) begin
            value_q <= {{(TW-1){1'b0}}, 1'b1};
        end else if (value_q != '1) begin
            value_q <= value_q + 1'b1;
        end
    end

    assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/ddr5_cmd_timing_checker.sv
`default_nettype none
// ============================================================================
//  Module   : ddr5_cmd_timing_checker
//  Purpose  : Per-channel DDR5 command-stream timing checker. Tracks per-bank
//             open state plus one elapsed timer per bank (since ACT when open,
//             since PRE when closed) and a refresh timer, and flags commands
//             that break tRCD/tRP/tRAS/tRFC minimums or basic protocol rules.
//  Ports    : clk, rst_n (async, active-low)
//             cmd_valid_i/cmd_type_i/cmd_bank_i - command stream
//             cfg_trcd_i/cfg_trp_i/cfg_tras_i/cfg_trfc_i - minimums (0 = off)
//             clr_count_i       - synchronous clear of the running count
//             violation_flag_o  - one-cycle pulse per violating command
//             violation_type_o  - causes of the most recent violation
//             violation_count_o - saturating count of violating commands
//             bank_open_o       - per-bank open state (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module ddr5_cmd_timing_checker
    import ddr5_timing_chk_pkg::*;
#(
    parameter int N_BANKS = 32,
    parameter int TW      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid_i,
    input  logic [2:0]                 cmd_type_i,
    input  logic [$clog2(N_BANKS)-1:0] cmd_bank_i,
    input  logic [TW-1:0]              cfg_trcd_i,
    input  logic [TW-1:0]              cfg_trp_i,
    input  logic [TW-1:0]              cfg_tras_i,
    input  logic [TW-1:0]              cfg_trfc_i,
    input  logic                       clr_count_i,
    output logic                       violation_flag_o,
    output logic [4:0]                 violation_type_o,
    output logic [15:0]                violation_count_o,
    output logic [N_BANKS-1:0]         bank_open_o
);

    logic [N_BANKS-1:0] open_q, open_d;
    logic [N_BANKS-1:0] bank_load;
    logic               ref_load;
    logic [TW-1:0]      bank_tmr [N_BANKS];
    logic [TW-1:0]      ref_tmr;
    logic [TW-1:0]      cur_tmr;
    viol_t              viol_d;
    logic               flag_q;
    viol_t              type_q;
    logic [COUNT_W-1:0] count_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_BANKS; gi++) begin : g_bank_tmr
            timing_sat_timer #(.TW(TW)) u_tmr (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (bank_load[gi]),
                .value_o (bank_tmr[gi])
            );
        end
    endgenerate

    timing_sat_timer #(.TW(TW)) u_ref_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ref_load),
        .value_o (ref_tmr)
    );

    // Commands always update bank state, even when they violate, so the
    // model follows the DRAM exactly as the controller drove it.
    always_comb begin
        viol_d    = '0;
        open_d    = open_q;
        bank_load = '0;
        ref_load  = 1'b0;
        cur_tmr   = bank_tmr[cmd_bank_i];
        if (cmd_valid_i) begin
            case (cmd_e'(cmd_type_i))
                CMD_ACT: begin
                    if (open_q[cmd_bank_i]) begin
                        viol_d[VIOL_PROTO] = 1'b1;
                    end else begin
                        // timer < cfg can never hold with cfg = 0
                        if (cur_tmr < cfg_trp_i)  viol_d[VIOL_TRP]  = 1'b1;
                        if (ref_tmr < cfg_trfc_i) viol_d[VIOL_TRFC] = 1'b1;
                    end
                    open_d[cmd_bank_i]    = 1'b1;
                    bank_load[cmd_bank_i] = 1'b1;
                end
                CMD_RD, CMD_WR: begin
                    if (!open_q[cmd_bank_i])       viol_d[VIOL_PROTO] = 1'b1;
                    else if (cur_tmr < cfg_trcd_i) viol_d[VIOL_TRCD]  = 1'b1;
                end
                CMD_PRE: begin
                    // PRE to a closed bank is a legal no-op; its tRP timer
                    // keeps running from the earlier precharge.
                    if (open_q[cmd_bank_i]) begin
                        if (cur_tmr < cfg_tras_i) viol_d[VIOL_TRAS] = 1'b1;
                        open_d[cmd_bank_i]    = 1'b0;
                        bank_load[cmd_bank_i] = 1'b1;
                    end
                end
                CMD_PREA: begin
                    for (int i = 0; i < N_BANKS; i++) begin
                        if (open_q[i]) begin
                            if (bank_tmr[i] < cfg_tras_i) viol_d[VIOL_TRAS] = 1'b1;
                            bank_load[i] = 1'b1;
                        end
                    end
                    open_d = '0;
                end
                CMD_REF: begin
                    if (|open_q) viol_d[VIOL_PROTO] = 1'b1;
                    ref_load = 1'b1;
                end
                CMD_RSVD: viol_d[VIOL_PROTO] = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q  <= '0;
            flag_q  <= 1'b0;
            type_q  <= '0;
            count_q <= '0;
        end else begin
            open_q <= open_d;
            flag_q <= |viol_d;
            if (|viol_d) type_q <= viol_d;
            // Clear wins, but a violation in the same cycle still counts once.
            if (clr_count_i) begin
                count_q <= {{(COUNT_W-1){1'b0}}, |viol_d};
            end else if (|viol_d && count_q != '1) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign violation_flag_o  = flag_q;
    assign violation_type_o  = type_q;
    assign violation_count_o = count_q;
    assign bank_open_o       = open_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr5_cmd_timing_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr5_cmd_timing_checker
//  Purpose  : Directed self-checking bench for ddr5_cmd_timing_checker with
//             tRCD=4, tRP=5, tRAS=10, tRFC=20. Each step drives one command
//             for one clock and samples outputs 1 ns after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr5_cmd_timing_checker;

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3,
                           PRE = 3'd4, PREA = 3'd5, REF = 3'd6, RSV = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_type = 3'd0;
    logic [4:0]  cmd_bank = 5'd0;
    logic [7:0]  cfg_trcd = 8'd4, cfg_trp = 8'd5, cfg_tras = 8'd10, cfg_trfc = 8'd20;
    logic        clr_count = 1'b0;
    logic        vflag;
    logic [4:0]  vtype;
    logic [15:0] vcount;
    logic [31:0] bopen;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ddr5_cmd_timing_checker #(.N_BANKS(32), .TW(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid_i       (cmd_valid),
        .cmd_type_i        (cmd_type),
        .cmd_bank_i        (cmd_bank),
        .cfg_trcd_i        (cfg_trcd),
        .cfg_trp_i         (cfg_trp),
        .cfg_tras_i        (cfg_tras),
        .cfg_trfc_i        (cfg_trfc),
        .clr_count_i       (clr_count),
        .violation_flag_o  (vflag),
        .violation_type_o  (vtype),
        .violation_count_o (vcount),
        .bank_open_o       (bopen)
    );

    // One command per clock; outputs then reflect that command.
    task automatic step(input logic [2:0] t, input logic [4:0] b);
        cmd_valid = (t != NOP);
        cmd_type  = t;
        cmd_bank  = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_type  = NOP;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(NOP, 5'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_type = NOP;
        clr_count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (vflag !== 1'b0) begin mismatched++; $display("FAIL reset_flag got %b want 0", vflag); end
        compared++; if (vtype !== 5'b0) begin mismatched++; $display("FAIL reset_type got %b want 00000", vtype); end
        compared++; if (vcount !== 16'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", vcount); end
        compared++; if (bopen !== 32'h0) begin mismatched++; $display("FAIL reset_bank_open got %h want 0", bopen); end
    endtask

    task automatic test_trcd();
        do_reset();
        step(ACT, 5'd3);
        compared++; if (vflag !== 1'b0) begin mismatched++; $display("FAIL trcd_act_flag got %b want 0", vflag); end
        compared++; if (bopen !== 32'h8) begin mismatched++; $display("FAIL trcd_bank_open got %h want 8", bopen); end
        nops(2);
        step(RD, 5'd3);
        compared++; if (vflag !== 1'b1) begin mismatched++; $display("FAIL trcd_flag got %b want 1", vflag); end
        compared++; if (vtype !== 5'b00001) begin mismatched++; $display("FAIL trcd_type got %b want 00001", vtype); end
        compared++; if (vcount !== 16'd1) begin mismatched++; $display("FAIL trcd_count got %0d want 1", vcount); end
        step(NOP, 5'd0);
        compared++; if (vflag !== 1'b0) begin mismatched++; $display("FAIL trcd_pulse_width got %b want 0", vflag); end
        do_reset();
        step(ACT, 5'd3);
        nops(3);
        step(WR, 5'd3);
        compared++; if (vflag !== 1'b0) begin mismatched++; $display("FAIL trcd_edge_flag got %b want 0", vflag); end
        compared++; if (vcount !== 16'd0) begin mismatched++; $display("FAIL trcd_edge_count got %0d want 0", vcount); end
    endtask

    task automatic test_trp_tras();
        do_reset();
        step(ACT, 5'd0);
        nops(9);
        step(PRE, 5'd0);
        compared++; if (vflag !== 1'b0) begin mismatched++; $display("FAIL tras_edge_flag got %b want 0", vflag); end
        nops(3);
        step(ACT, 5'd0);
        compared++; if (vtype !== 5'b00010) begin mismatched++; $display("FAIL trp_type got %b want 00010", vtype); end
        compared++; if (vcount !== 16'd1) begin mismatched++; $display("FAIL trp_count got %0d want 1", vcount); end
        do_reset();
        step(ACT, 5'd0);
        nops(8);
        step(PRE, 5'd0);
        compared++; if (vtype !== 5'b00100) begin mismatched++; $display("FAIL tras_type got %b want 00100", vtype); end
        compared++; if (bopen !== 32'h0) begin mismatched++; $display("FAIL tras_bank_closed got %h want 0", bopen); end
        // PREA with two young banks: one tRAS cause, one count, all closed
        do_reset();
        step(ACT, 5'd1);
        step(ACT, 5'd2);
        step(PREA, 5'd0);
        compared++; if (vtype !== 5'b00100 || vcount !== 16'd1) begin mismatched++; $display("FAIL prea_tras got type %b count %0d want 00100 1", vtype, vcount); end
        compared++; if (bopen !== 32'h0) begin mismatched++; $display("FAIL prea_bank_open got %h want 0", bopen); end
    endtask

    task automatic test_trfc();
        do_reset();
        step(REF, 5'd0);
        compared++; if (vflag !== 1'b0) begin mismatched++; $display("FAIL ref_closed_flag got %b want 0", vflag); end
        nops(18);
        step(ACT, 5'd1);
        compared++; if (vtype !== 5'b01000 || vflag !== 1'b1) begin mismatched++; $display("FAIL trfc_type got %b flag %b want 01000 1", vtype, vflag); end
        step(ACT, 5'd2);
        compared++; if (vflag !== 1'b0) begin mismatched++; $display("FAIL trfc_edge_flag got %b want 0", vflag); end
        compared++; if (vtype !== 5'b01000) begin mismatched++; $display("FAIL type_sticky got %b want 01000", vtype); end
        step(ACT, 5'd5);
        step(REF, 5'd0);
        compared++; if (vtype !== 5'b10000) begin mismatched++; $display("FAIL ref_open_type got %b want 10000", vtype); end
        compared++; if (vcount !== 16'd2) begin mismatched++; $display("FAIL ref_open_count got %0d want 2", vcount); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(ACT, 5'd3);
        step(RD, 5'd7);
        compared++; if (vflag !== 1'b1 || vtype !== 5'b10000) begin mismatched++; $display("FAIL b2b_first got flag %b type %b want 1 10000", vflag, vtype); end
        step(ACT, 5'd3);
        compared++; if (vflag !== 1'b1 || vtype !== 5'b10000) begin mismatched++; $display("FAIL b2b_second got flag %b type %b want 1 10000", vflag, vtype); end
        compared++; if (vcount !== 16'd2) begin mismatched++; $display("FAIL b2b_count got %0d want 2", vcount); end
        // PRE at t10 then REF at t11, ACT at t12: tRP (2<5) and tRFC (1<20)
        do_reset();
        step(ACT, 5'd0);
        nops(9);
        step(PRE, 5'd0);
        step(REF, 5'd0);
        step(ACT, 5'd0);
        compared++; if (vtype !== 5'b01010) begin mismatched++; $display("FAIL multi_type got %b want 01010", vtype); end
        compared++; if (vcount !== 16'd1) begin mismatched++; $display("FAIL multi_count got %0d want 1", vcount); end
    endtask

    task automatic test_count_sat();
        do_reset();
        cmd_valid = 1'b1;
        cmd_type  = RSV;
        repeat (65540) @(posedge clk);
        #1;
        compared++; if (vcount !== 16'hFFFF) begin mismatched++; $display("FAIL count_saturate got %h want FFFF", vcount); end
        clr_count = 1'b1;
        step(RSV, 5'd0);
        compared++; if (vcount !== 16'd1) begin mismatched++; $display("FAIL clr_with_viol got %0d want 1", vcount); end
        step(NOP, 5'd0);
        clr_count = 1'b0;
        compared++; if (vcount !== 16'd0) begin mismatched++; $display("FAIL clr_alone got %0d want 0", vcount); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(ACT, 5'd4);
        step(RD, 5'd9);
        compared++; if (vflag !== 1'b1 || vcount !== 16'd1) begin mismatched++; $display("FAIL mid_pre_flag got %b count %0d want 1 1", vflag, vcount); end
        // Violating command on the bus while reset asserts: must be dropped
        cmd_valid = 1'b1;
        cmd_type  = RD;
        cmd_bank  = 5'd9;
        rst_n     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++;
            if (vflag !== 1'b0 || vtype !== 5'b0 || vcount !== 16'd0 || bopen !== 32'h0) begin
                mismatched++;
                $display("FAIL mid_reset_outputs cyc %0d got flag %b type %b count %0d open %h want all 0", c, vflag, vtype, vcount, bopen);
            end
            @(posedge clk);
        end
        #1;
        cmd_valid = 1'b0;
        cmd_type  = NOP;
        rst_n     = 1'b1;
        step(RD, 5'd4);
        compared++; if (vflag !== 1'b1 || vtype !== 5'b10000) begin mismatched++; $display("FAIL post_reset_rd got flag %b type %b want 1 10000", vflag, vtype); end
        step(ACT, 5'd4);
        compared++; if (vflag !== 1'b0 || vcount !== 16'd1) begin mismatched++; $display("FAIL post_reset_act got flag %b count %0d want 0 1", vflag, vcount); end
    endtask

    initial begin
        test_reset();
        test_trcd();
        test_trp_tras();
        test_trfc();
        test_back_to_back();
        test_count_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
